// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Display sink for the CPU write-back stage. It accepts a 32-bit value over a
// valid/ready handshake and holds off the producer for MIN_DWELL cycles after
// every accepted value. It scans the held value as 8 hex digits onto a
// common-anode seven-segment display, with one digit enabled at a time.
//
// Parameters:
//   REFRESH_DIV - cycles each digit stays enabled (>= 1)
//   MIN_DWELL   - cycles disp_ready stays low after an accept (0 = no hold-off)
//   BLANK_LZ    - 1 blanks leading-zero digits above digit 0
//
// Ports:
//   Clk        in   1   system clock, rising edge
//   Rst        in   1   asynchronous active-low reset
//   disp_valid in   1   producer offers disp_data
//   disp_ready out  1   driver can accept a value this cycle
//   disp_data  in  32   value to show; nibble i -> digit i (digit 0 rightmost)
//   out7       out  7   segments, active low, bit6=a .. bit0=g
//   en_out     out  8   digit enables, active low, bit i -> digit i
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int MIN_DWELL   = 50000000,
    parameter int BLANK_LZ    = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        disp_valid,
    output logic        disp_ready,
    input  logic [31:0] disp_data,
    output logic [6:0]  out7,
    output logic [7:0]  en_out
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    // The dwell counter counts down from MIN_DWELL-1 to 0 while ready is low,
    // so ready is low for exactly MIN_DWELL sampling edges.
    localparam logic [DW-1:0] DWELL_LOAD = DW'((MIN_DWELL > 0) ? (MIN_DWELL - 1) : 0);

    // Hex digit to active-low segment pattern, order abcdefg.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    logic [31:0]   r_shown;
    logic [2:0]    r_idx;
    logic [RW-1:0] r_refresh_cnt;
    logic [DW-1:0] r_dwell_cnt;
    logic          r_ready;
    logic [6:0]    r_out7;
    logic [7:0]    r_en_out;

    logic          w_transfer;
    logic [31:0]   w_shifted;
    logic          w_blank;
    logic [6:0]    w_seg;
    logic [7:0]    w_en;

    assign w_transfer = disp_valid & r_ready;

    // Shifting the current digit down to bit 0 gives both its nibble and,
    // through the remaining upper bits, whether it is a leading zero.
    assign w_shifted  = r_shown >> {r_idx, 2'b00};
    assign w_blank    = (BLANK_LZ != 0) && (r_idx != 3'd0) && (w_shifted == 32'd0);
    assign w_en       = ~(8'b0000_0001 << r_idx);

    // Segment pattern for the digit currently indexed, including blanking.
    always_comb begin
        w_seg = 7'h7F;
        if (w_blank) begin
            w_seg = 7'h7F;
        end else begin
            w_seg = seg_decode(w_shifted[3:0]);
        end
    end

    // Refresh counter and scan index; free-running, unaffected by transfers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_refresh_cnt <= {RW{1'b0}};
            r_idx         <= 3'd0;
        end else if (r_refresh_cnt == REFRESH_LAST) begin
            r_refresh_cnt <= {RW{1'b0}};
            r_idx         <= r_idx + 3'd1;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + RW'(1);
        end
    end

    // Handshake capture and post-accept dwell hold-off.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_shown     <= 32'd0;
            r_ready     <= 1'b1;
            r_dwell_cnt <= {DW{1'b0}};
        end else if (!r_ready) begin
            if (r_dwell_cnt == {DW{1'b0}}) begin
                r_ready <= 1'b1;
            end else begin
                r_dwell_cnt <= r_dwell_cnt - DW'(1);
            end
        end else if (w_transfer) begin
            r_shown <= disp_data;
            if (MIN_DWELL > 0) begin
                r_ready     <= 1'b0;
                r_dwell_cnt <= DWELL_LOAD;
            end else begin
                r_ready <= 1'b1;
            end
        end else begin
            r_ready <= 1'b1;
        end
    end

    // Registered display outputs, one cycle behind index and shown value.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_out7   <= 7'h7F;
            r_en_out <= 8'hFF;
        end else begin
            r_out7   <= w_seg;
            r_en_out <= w_en;
        end
    end

    assign disp_ready = r_ready;
    assign out7       = r_out7;
    assign en_out     = r_en_out;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    logic        Clk;
    logic        Rst;

    // Instance A: REFRESH_DIV=4, MIN_DWELL=3, BLANK_LZ=1
    logic        valid_a;
    logic        ready_a;
    logic [31:0] data_a;
    logic [6:0]  out7_a;
    logic [7:0]  en_a;

    // Instance B: REFRESH_DIV=1, MIN_DWELL=0, BLANK_LZ=1
    logic        valid_b;
    logic        ready_b;
    logic [31:0] data_b;
    logic [6:0]  out7_b;
    logic [7:0]  en_b;

    // Instance C: REFRESH_DIV=1, MIN_DWELL=0, BLANK_LZ=0
    logic        valid_c;
    logic        ready_c;
    logic [31:0] data_c;
    logic [6:0]  out7_c;
    logic [7:0]  en_c;

    int checks;
    int failures;

    seg7_scan_driver #(.REFRESH_DIV(4), .MIN_DWELL(3), .BLANK_LZ(1)) u_a (
        .Clk(Clk), .Rst(Rst), .disp_valid(valid_a), .disp_ready(ready_a),
        .disp_data(data_a), .out7(out7_a), .en_out(en_a)
    );

    seg7_scan_driver #(.REFRESH_DIV(1), .MIN_DWELL(0), .BLANK_LZ(1)) u_b (
        .Clk(Clk), .Rst(Rst), .disp_valid(valid_b), .disp_ready(ready_b),
        .disp_data(data_b), .out7(out7_b), .en_out(en_b)
    );

    seg7_scan_driver #(.REFRESH_DIV(1), .MIN_DWELL(0), .BLANK_LZ(0)) u_c (
        .Clk(Clk), .Rst(Rst), .disp_valid(valid_c), .disp_ready(ready_c),
        .disp_data(data_c), .out7(out7_c), .en_out(en_c)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [7:0] get_en(input int inst);
        case (inst)
            0:       return en_a;
            1:       return en_b;
            default: return en_c;
        endcase
    endfunction

    // Wait (bounded) until instance inst enables digit d.
    task automatic wait_digit(input int inst, input int d);
        logic [7:0] want;
        bit found;
        want  = ~(8'b0000_0001 << d);
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (get_en(inst) === want) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        assert (found) else begin
            failures++;
            $error("FAIL wait_digit inst=%0d observed=%h expected=%h (timeout)", inst, get_en(inst), want);
        end
    endtask

    logic [6:0] beef_seg [8];
    logic [6:0] b_seg    [8];

    initial begin
        checks   = 0;
        failures = 0;
        valid_a = 1'b0; data_a = 32'd0;
        valid_b = 1'b0; data_b = 32'd0;
        valid_c = 1'b0; data_c = 32'd0;
        Rst = 1'b1;
        #2;
        Rst = 1'b0;
        tick();
        tick();

        // ---- Reset state ----
        check("rst_en_a",    {24'd0, en_a},    32'h0000_00FF);
        check("rst_out7_a",  {25'd0, out7_a},  32'h0000_007F);
        check("rst_ready_a", {31'd0, ready_a}, 32'd1);
        check("rst_en_b",    {24'd0, en_b},    32'h0000_00FF);

        // ---- Test 1: scan cadence with REFRESH_DIV=4 ----
        Rst = 1'b1;
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                check($sformatf("scan_en_d%0d_c%0d", d, c), {24'd0, en_a},
                      {24'd0, ~(8'b0000_0001 << d)});
                check($sformatf("scan_out7_d%0d_c%0d", d, c), {25'd0, out7_a},
                      (d == 0) ? 32'h0000_0001 : 32'h0000_007F);
            end
        end
        tick();
        check("scan_wrap_en", {24'd0, en_a}, 32'h0000_00FE);

        // ---- Test 2/3: accept BEEF, dwell of 3, ignore data during dwell ----
        valid_a = 1'b1;
        data_a  = 32'h0000_BEEF;
        tick();                               // edge k: accepted
        check("dwell_ready_k", {31'd0, ready_a}, 32'd0);
        data_a = 32'h1234_5678;               // offered during dwell
        tick();
        check("dwell_ready_k1", {31'd0, ready_a}, 32'd0);
        tick();
        check("dwell_ready_k2", {31'd0, ready_a}, 32'd0);
        tick();
        check("dwell_ready_k3", {31'd0, ready_a}, 32'd1);
        valid_a = 1'b0;

        beef_seg[0] = 7'b0111000; beef_seg[1] = 7'b0110000;
        beef_seg[2] = 7'b0110000; beef_seg[3] = 7'b1100000;
        beef_seg[4] = 7'h7F; beef_seg[5] = 7'h7F; beef_seg[6] = 7'h7F; beef_seg[7] = 7'h7F;
        for (int d = 0; d < 8; d++) begin
            wait_digit(0, d);
            check($sformatf("beef_d%0d", d), {25'd0, out7_a}, {25'd0, beef_seg[d]});
        end

        valid_a = 1'b1;
        data_a  = 32'h1234_5678;
        tick();
        valid_a = 1'b0;
        check("accept2_ready", {31'd0, ready_a}, 32'd0);
        wait_digit(0, 7);
        tick();                               // display certainly refreshed from new value
        wait_digit(0, 7);
        check("d7_is_1", {25'd0, out7_a}, 32'h0000_004F);
        wait_digit(0, 0);
        check("d0_is_8", {25'd0, out7_a}, 32'h0000_0000);

        // ---- Test 4: back-to-back accepts, MIN_DWELL=0, REFRESH_DIV=1 ----
        valid_b = 1'b1;
        data_b  = 32'h0000_0001;
        check("b2b_ready_0", {31'd0, ready_b}, 32'd1);
        tick();
        check("b2b_ready_1", {31'd0, ready_b}, 32'd1);
        data_b = 32'h8000_0000;
        tick();
        check("b2b_ready_2", {31'd0, ready_b}, 32'd1);
        valid_b = 1'b0;
        b_seg[0] = 7'b0000001; b_seg[1] = 7'b0000001; b_seg[2] = 7'b0000001;
        b_seg[3] = 7'b0000001; b_seg[4] = 7'b0000001; b_seg[5] = 7'b0000001;
        b_seg[6] = 7'b0000001; b_seg[7] = 7'b0000000;
        tick();
        for (int d = 0; d < 8; d++) begin
            wait_digit(1, d);
            check($sformatf("b2b_d%0d", d), {25'd0, out7_b}, {25'd0, b_seg[d]});
        end

        // ---- Test 5: no blanking, value 0 ----
        for (int d = 0; d < 8; d++) begin
            wait_digit(2, d);
            check($sformatf("noblank_d%0d", d), {25'd0, out7_c}, 32'h0000_0001);
        end

        // ---- Test 6: reset mid-dwell while digit 5 is enabled ----
        wait_digit(0, 4);
        wait_digit(0, 5);                     // first cycle of digit 5
        valid_a = 1'b1;
        data_a  = 32'h00AB_CDEF;
        tick();                               // accepted, second cycle of digit 5
        valid_a = 1'b0;
        check("mid_ready", {31'd0, ready_a}, 32'd0);
        check("mid_en",    {24'd0, en_a},    32'h0000_00DF);
        #2;
        Rst = 1'b0;
        #1;
        check("arst_en",    {24'd0, en_a},    32'h0000_00FF);
        check("arst_out7",  {25'd0, out7_a},  32'h0000_007F);
        check("arst_ready", {31'd0, ready_a}, 32'd1);
        tick();
        tick();
        Rst = 1'b1;
        tick();
        check("restart_en",    {24'd0, en_a},    32'h0000_00FE);
        check("restart_out7",  {25'd0, out7_a},  32'h0000_0001);
        check("restart_ready", {31'd0, ready_a}, 32'd1);
        tick();
        tick();
        tick();
        tick();
        check("restart_en_d1",   {24'd0, en_a},   32'h0000_00FD);
        check("restart_out7_d1", {25'd0, out7_a}, 32'h0000_007F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
